// File: rtl/accumulator_scheduler.sv
// Round-robin scheduler that lends one wrapping accumulator to NUM_REQ burst requesters
// and returns each burst's sum tagged with the owner's index.
module accumulator_scheduler #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int LEN_WIDTH = 8,
  parameter int ID_WIDTH  = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   i_req_len,
  output logic [NUM_REQ-1:0]             o_gnt,
  input  logic [WIDTH-1:0]               i_s_data,
  input  logic                           i_s_valid,
  output logic                           o_s_ready,
  output logic [WIDTH-1:0]               o_res_data,
  output logic [ID_WIDTH-1:0]            o_res_id,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic                           o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ID_WIDTH-1:0]   r_sel, r_last, w_win, w_idx;
  logic [LEN_WIDTH-1:0]  r_len, r_count, w_win_len;
  logic [WIDTH-1:0]      r_acc;
  logic                  w_any, w_hs, w_last_hs;

  // Search upward from the last served requester so it drops to lowest priority.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_win_len = i_req_len[int'(w_win)*LEN_WIDTH +: LEN_WIDTH];
  assign w_hs      = (r_state == S_ACCUM) && i_s_valid;
  assign w_last_hs = w_hs && (r_count == r_len - LEN_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_gnt       = '0;
    o_s_ready   = 1'b0;
    o_res_valid = 1'b0;
    o_res_data  = '0;
    o_res_id    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = (w_win_len != '0) ? S_ACCUM : S_DONE;
      end
      S_ACCUM: begin
        o_gnt[r_sel] = 1'b1;
        o_s_ready    = 1'b1;
        if (w_last_hs) w_next = S_DONE;
      end
      S_DONE: begin
        o_res_valid = 1'b1;
        o_res_data  = r_acc;
        o_res_id    = r_sel;
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  // Pointer resets to NUM_REQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel   <= '0;
      r_len   <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_last  <= ID_WIDTH'(NUM_REQ-1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_len   <= w_win_len;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc   <= r_acc + i_s_data;
            r_count <= r_count + LEN_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (i_res_ready) r_last <= r_sel;
        end
        default: ;
      endcase
    end
  end

endmodule
